multi_bank_buffer: RTL and testbench
====================================

MULTI_BANK_BUFFER -- requirements
Module: multi_bank_buffer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, number of parallel memory banks (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, bits per bank word.
REQ-003 SHALL have parameter DEPTH, default 1024, words per bank; ADDR_W = $clog2(DEPTH); SUM_W = DATA_W + $clog2(NUM_BANKS).
REQ-004 SHALL have one clock and a synchronous, active-high reset; all other ports follow it:
  clk  in  1  sole clock, rising edge
  rst  in  1  synchronous, active-high reset
  wr_en  in  1  write all banks this cycle
  wr_addr  in  ADDR_W  write address, shared by all banks
  wr_data  in  NUM_BANKS*DATA_W  bank k data in slice [k*DATA_W +: DATA_W]
  rd_en  in  1  single read request
  rd_addr  in  ADDR_W  single read address
  rd_mask  in  NUM_BANKS  banks taking part in the read
  rd_mode  in  1  0 = select lowest masked bank, 1 = sum of masked banks
  burst_start  in  1  start an auto-increment read burst
  burst_base  in  ADDR_W  first burst address
  burst_len  in  ADDR_W+1  burst length in words (0..DEPTH)
  rd_data  out  SUM_W  combined read result
  rd_valid  out  1  rd_data valid this cycle
  burst_busy  out  1  burst engine not idle
  burst_done  out  1  one-cycle pulse at burst completion

Function
REQ-005 SHALL write wr_data slice k to bank k at wr_addr on every cycle wr_en=1.
REQ-006 SHALL present a read result 2 cycles after the issuing cycle (1 cycle RAM, 1 cycle combine register); rd_valid asserted in exactly that cycle.
REQ-007 SHALL, in mode 0, output the lowest-index masked bank word zero-extended to SUM_W.
REQ-008 SHALL, in mode 1, output the unsigned sum of all masked bank words at SUM_W; no overflow is possible.
REQ-009 SHALL, with rd_mask all zero, output rd_data=0 with rd_valid still asserted.
REQ-010 SHALL capture rd_mask and rd_mode with the issuing request; later changes do not affect in-flight reads.
REQ-011 SHALL sustain one read issue per cycle, back to back, with no bubbles.
REQ-012 SHALL, on read and write to the same address in the same cycle, return the old data (read-first), unless REQ-021 applies.
REQ-013 SHALL implement a burst FSM with states IDLE, BURST and DRAIN.
REQ-014 SHALL, in IDLE with burst_start=1, capture burst_base, burst_len, rd_mask and rd_mode; go to BURST if burst_len>0, else go straight to DRAIN.
REQ-015 SHALL, in BURST, issue one read per cycle at base, base+1, ..., wrapping from DEPTH-1 to 0; go to DRAIN after the burst_len-th issue.
REQ-016 SHALL, in DRAIN, wait until no read is in flight, pulse burst_done for one cycle, then return to IDLE; burst_len=0 gives burst_done exactly 1 cycle after burst_start.
REQ-017 SHALL drive burst_busy=1 in BURST and DRAIN, and in no other state.
REQ-018 SHALL ignore rd_en and burst_start while burst_busy=1; writes remain allowed.

Reset
REQ-019 SHALL, on rst=1: set FSM to IDLE, rd_valid=0, burst_busy=0, burst_done=0, rd_data=0, and cancel in-flight reads (no rd_valid after reset).
REQ-020 SHALL NOT clear memory contents on reset; a mid-burst reset aborts the burst without a burst_done pulse.

Configuration
REQ-021 SHALL, when macro MULTI_BANK_BUFFER_FWD_EN is defined, forward wr_data to the read path for a same-cycle same-address read (write-first); when undefined, read-first per REQ-012.

Structure
REQ-022 SHALL place the FSM state enum and the mode encodings (RD_MODE_SEL=0, RD_MODE_SUM=1) in shared package mbb_pkg.
REQ-023 SHALL instantiate one sub-module per bank, mbb_bank_ram (simple dual-port, one clock, inferable as block RAM).

Verification
REQ-024 Write 1,2,3,4,5 to bank0 and 2,3,4,5,6 to bank1 at addr 0..4; read addr 1..4 with mask=01, mode 0 -> rd_data 2,3,4,5, each 2 cycles after issue.
REQ-025 Same data, mask=10, mode 0 -> 3,4,5,6; mask=11, mode 1 -> 5,7,9,11; mask=00 -> 0 with rd_valid=1.
REQ-026 Burst base=DEPTH-2, len=4, mask=11, mode 1 -> addresses DEPTH-2, DEPTH-1, 0, 1 in order, 4 consecutive rd_valid, then burst_done pulse, burst_busy low next cycle.
REQ-027 burst_len=0 -> burst_done 1 cycle after start, no rd_valid; burst_start and rd_en during a burst -> ignored.
REQ-028 Write 9 and read addr 3 in the same cycle (old value 4) -> 4 without the macro, 9 with MULTI_BANK_BUFFER_FWD_EN.
REQ-029 rst asserted on cycle 2 of a 10-word burst -> rd_valid, burst_busy and burst_done low from the next cycle; a later read of addr 0 returns its pre-reset contents.

Source files
------------

// File: rtl/mbb_pkg.sv
// Shared definitions for multi_bank_buffer: burst FSM states and read-mode encodings.
package mbb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } burst_state_e;

  localparam logic RD_MODE_SEL = 1'b0;
  localparam logic RD_MODE_SUM = 1'b1;

endpackage

// File: rtl/mbb_bank_ram.sv
// One bank of multi_bank_buffer: simple dual-port RAM, one clock, registered read port.
// Read and write to the same address in one cycle return the old word (read-first).
module mbb_bank_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/multi_bank_buffer.sv
// Multi-bank buffer: shared-address writes to all banks, masked select/sum reads, burst engine.
// Build option: define MULTI_BANK_BUFFER_FWD_EN for write-first forwarding on same-address reads.
module multi_bank_buffer
  import mbb_pkg::*;
#(
  parameter  int NUM_BANKS = 2,
  parameter  int DATA_W    = 8,
  parameter  int DEPTH     = 1024,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int SUM_W     = DATA_W + $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0] wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  input  logic [NUM_BANKS-1:0]        rd_mask,
  input  logic                        rd_mode,
  input  logic                        burst_start,
  input  logic [ADDR_W-1:0]           burst_base,
  input  logic [ADDR_W:0]             burst_len,
  output logic [SUM_W-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        burst_busy,
  output logic                        burst_done
);

  burst_state_e         state_q;
  logic [ADDR_W-1:0]    burst_addr_q;
  logic [ADDR_W:0]      burst_rem_q;
  logic [NUM_BANKS-1:0] burst_mask_q;
  logic                 burst_mode_q;
  logic                 burst_done_q;

  logic                 s1_valid_q;
  logic [NUM_BANKS-1:0] s1_mask_q;
  logic                 s1_mode_q;
  logic [SUM_W-1:0]     rd_data_q, rd_data_d;
  logic                 rd_valid_q;

  logic                 issue;
  logic [ADDR_W-1:0]    issue_addr;
  logic [NUM_BANKS-1:0] issue_mask;
  logic                 issue_mode;
  logic [DATA_W-1:0]    bank_rd   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_word [NUM_BANKS];

  // Requests are valid-only (no ready): rd_en and burst_start are taken only while
  // burst_busy is low, and burst_start wins over rd_en when both arrive together.
  always_comb begin
    issue      = (state_q == ST_BURST) || (state_q == ST_IDLE && rd_en && !burst_start);
    issue_addr = (state_q == ST_BURST) ? burst_addr_q : rd_addr;
    issue_mask = (state_q == ST_BURST) ? burst_mask_q : rd_mask;
    issue_mode = (state_q == ST_BURST) ? burst_mode_q : rd_mode;
  end

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    mbb_bank_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk_i     (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data[k*DATA_W +: DATA_W]),
      .rd_en_i   (issue),
      .rd_addr_i (issue_addr),
      .rd_data_o (bank_rd[k])
    );
  end

`ifdef MULTI_BANK_BUFFER_FWD_EN
  logic                        fwd_hit_q;
  logic [NUM_BANKS*DATA_W-1:0] fwd_data_q;

  always_ff @(posedge clk) begin
    if (issue) begin
      fwd_hit_q  <= wr_en && (wr_addr == issue_addr);
      fwd_data_q <= wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++)
      bank_word[k] = fwd_hit_q ? fwd_data_q[k*DATA_W +: DATA_W] : bank_rd[k];
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_BANKS; k++) bank_word[k] = bank_rd[k];
  end
`endif

  always_comb begin
    logic found;
    rd_data_d = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (s1_mask_q[k]) begin
        if (s1_mode_q == RD_MODE_SUM) begin
          rd_data_d = rd_data_d + SUM_W'(bank_word[k]);
        end else if (!found) begin
          rd_data_d = SUM_W'(bank_word[k]);
          found     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_mask_q <= issue_mask;
        s1_mode_q <= issue_mode;
      end
      rd_valid_q <= s1_valid_q;
      if (s1_valid_q) rd_data_q <= rd_data_d;
    end
  end

  // burst_done is raised one cycle ahead: in DRAIN no new reads issue, so once stage 1
  // is empty the output register empties on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      burst_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          burst_done_q <= 1'b0;
          if (burst_start) begin
            burst_addr_q <= burst_base;
            burst_rem_q  <= burst_len;
            burst_mask_q <= rd_mask;
            burst_mode_q <= rd_mode;
            if (burst_len != '0) begin
              state_q <= ST_BURST;
            end else begin
              state_q      <= ST_DRAIN;
              burst_done_q <= !s1_valid_q;
            end
          end
        end
        ST_BURST: begin
          burst_addr_q <= (burst_addr_q == ADDR_W'(DEPTH - 1)) ? '0
                                                               : burst_addr_q + ADDR_W'(1);
          burst_rem_q  <= burst_rem_q - (ADDR_W + 1)'(1);
          if (burst_rem_q == (ADDR_W + 1)'(1)) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (burst_done_q) begin
            state_q      <= ST_IDLE;
            burst_done_q <= 1'b0;
          end else if (!s1_valid_q) begin
            burst_done_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          burst_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign burst_busy = (state_q != ST_IDLE);
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_multi_bank_buffer.sv
// Self-checking bench for multi_bank_buffer (default parameters: 2 banks x 8 bits x 1024 words).
module tb_multi_bank_buffer;

  localparam int NB    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int SW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NB*DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [NB-1:0] rd_mask;
  logic          rd_mode;
  logic          burst_start;
  logic [AW-1:0] burst_base;
  logic [AW:0]   burst_len;
  logic [SW-1:0] rd_data;
  logic          rd_valid;
  logic          burst_busy;
  logic          burst_done;

  multi_bank_buffer #(
    .NUM_BANKS (NB),
    .DATA_W    (DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_mask     (rd_mask),
    .rd_mode     (rd_mode),
    .burst_start (burst_start),
    .burst_base  (burst_base),
    .burst_len   (burst_len),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .burst_busy  (burst_busy),
    .burst_done  (burst_done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  // scoreboard: expected read data and the cycle it must appear in
  logic [SW-1:0] exp_q[$];
  int            due_q[$];
  logic [DW-1:0] m0 [DEPTH];
  logic [DW-1:0] m1 [DEPTH];

  function automatic logic [SW-1:0] model_rd(input int a, input logic [1:0] mask, input logic mode);
    logic [SW-1:0] r;
    r = '0;
    if (mode) begin
      if (mask[0]) r = r + SW'(m0[a]);
      if (mask[1]) r = r + SW'(m1[a]);
    end else if (mask[0]) begin
      r = SW'(m0[a]);
    end else if (mask[1]) begin
      r = SW'(m1[a]);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rd_valid cyc=%0d rd_data=%0d", cyc, rd_data);
        end else begin
          logic [SW-1:0] e;
          int            d;
          e = exp_q.pop_front();
          d = due_q.pop_front();
          if (rd_data !== e || cyc !== d) begin
            n_fail++;
            $display("FAIL rd_data cyc=%0d got=%0d expected=%0d due_cyc=%0d", cyc, rd_data, e, d);
          end
        end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missing_rd_valid cyc=%0d expected=%0d", cyc, exp_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_mask = '0; rd_mode = 1'b0;
    burst_start = 1'b0; burst_base = '0; burst_len = '0;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = {d1, d0};
    m0[a] = d0; m1[a] = d1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic issue_read(input int a, input logic [1:0] mask, input logic mode);
    rd_en = 1'b1; rd_addr = AW'(a); rd_mask = mask; rd_mode = mode;
    exp_q.push_back(model_rd(a, mask, mode));
    due_q.push_back(cyc + 2);
    step();
    rd_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
    step();
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    n_cmp += 4;
    if (rd_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rd_valid got=%b required=0", rd_valid); end
    if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b required=0", burst_busy); end
    if (burst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b required=0", burst_done); end
    if (rd_data !== '0)      begin n_fail++; $display("FAIL reset_rd_data got=%0d required=0", rd_data); end
    rst = 1'b0;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_basic_reads();
    for (int a = 0; a < 5; a++) do_write(a, DW'(a + 1), DW'(a + 2));
    for (int a = 1; a <= 4; a++) issue_read(a, 2'b01, 1'b0);
    for (int a = 1; a <= 4; a++) issue_read(a, 2'b10, 1'b0);
    for (int a = 1; a <= 4; a++) issue_read(a, 2'b11, 1'b1);
    for (int a = 1; a <= 4; a++) issue_read(a, 2'b00, 1'b0);
    issue_read(2, 2'b00, 1'b1);
    issue_read(0, 2'b11, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      issue_read(int'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    wait_drain();
  endtask

  task automatic test_burst();
    int c;
    do_write(DEPTH - 2, 8'd200, 8'd100);
    do_write(DEPTH - 1, 8'd255, 8'd255);
    rd_mask = 2'b11; rd_mode = 1'b1;
    burst_start = 1'b1; burst_base = AW'(DEPTH - 2); burst_len = (AW + 1)'(4);
    c = cyc;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(model_rd((DEPTH - 2 + i - 1) % DEPTH, 2'b11, 1'b1));
      due_q.push_back(c + 2 + i);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      burst_start = (i >= 2 && i <= 6);
      rd_en       = (i >= 2 && i <= 6);
      burst_len   = '0;
      rd_addr     = AW'(3);
      rd_mask     = 2'b01;
      rd_mode     = 1'b0;
      n_cmp += 2;
      if (burst_done !== (i == 7)) begin
        n_fail++; $display("FAIL burst_done cycle=%0d got=%b required=%b", i, burst_done, (i == 7));
      end
      if (burst_busy !== (i <= 7)) begin
        n_fail++; $display("FAIL burst_busy cycle=%0d got=%b required=%b", i, burst_busy, (i <= 7));
      end
    end
    idle_inputs();
    wait_drain();
  endtask

  task automatic test_burst_zero();
    burst_start = 1'b1; burst_base = AW'(5); burst_len = '0;
    for (int i = 1; i <= 3; i++) begin
      step();
      burst_start = 1'b0;
      n_cmp += 2;
      if (burst_done !== (i == 1)) begin
        n_fail++; $display("FAIL zero_len_done cycle=%0d got=%b required=%b", i, burst_done, (i == 1));
      end
      if (burst_busy !== (i == 1)) begin
        n_fail++; $display("FAIL zero_len_busy cycle=%0d got=%b required=%b", i, burst_busy, (i == 1));
      end
    end
    idle_inputs();
  endtask

  task automatic test_same_addr();
    logic [SW-1:0] old_v;
    old_v = model_rd(3, 2'b01, 1'b0);
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = {8'd10, 8'd9};
    rd_en = 1'b1; rd_addr = AW'(3); rd_mask = 2'b01; rd_mode = 1'b0;
    m0[3] = 8'd9; m1[3] = 8'd10;
`ifdef MULTI_BANK_BUFFER_FWD_EN
    exp_q.push_back(model_rd(3, 2'b01, 1'b0));
`else
    exp_q.push_back(old_v);
`endif
    due_q.push_back(cyc + 2);
    step();
    idle_inputs();
    issue_read(3, 2'b11, 1'b1);
    issue_read(3, 2'b10, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_midburst();
    rd_mask = 2'b11; rd_mode = 1'b1;
    burst_start = 1'b1; burst_base = '0; burst_len = (AW + 1)'(10);
    step();
    burst_start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp += 3;
      if (rd_valid !== 1'b0)   begin n_fail++; $display("FAIL midburst_rd_valid cycle=%0d got=%b required=0", i, rd_valid); end
      if (burst_busy !== 1'b0) begin n_fail++; $display("FAIL midburst_busy cycle=%0d got=%b required=0", i, burst_busy); end
      if (burst_done !== 1'b0) begin n_fail++; $display("FAIL midburst_done cycle=%0d got=%b required=0", i, burst_done); end
      step();
    end
    idle_inputs();
    issue_read(0, 2'b11, 1'b1);
    issue_read(0, 2'b01, 1'b0);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_basic_reads();
    test_back_to_back();
    test_burst();
    test_burst_zero();
    test_same_addr();
    test_reset_midburst();
    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
